// File: rtl/mem_port_arbiter.sv
// Single-port BRAM arbiter shared by instruction fetch and the MEM stage.
// Data wins contested cycles until the starvation limit forces an IF grant; a tag pipe routes read returns.
module mem_port_arbiter #(
  parameter int XLEN       = 64,
  parameter int ADDR_W     = 32,
  parameter int RD_LAT     = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                ifReq,
  input  logic [ADDR_W-1:0]   ifAddr,
  output logic                ifGnt,
  output logic                ifRvalid,
  output logic [31:0]         ifRdata,
  input  logic                dReq,
  input  logic                dWe,
  input  logic [ADDR_W-1:0]   dAddr,
  input  logic [XLEN-1:0]     dWdata,
  input  logic [XLEN/8-1:0]   dBe,
  output logic                dGnt,
  output logic                dRvalid,
  output logic [XLEN-1:0]     dRdata,
  input  logic                flush,
  output logic                memEn,
  output logic                memWe,
  output logic [ADDR_W-1:0]   memAddr,
  output logic [XLEN-1:0]     memWdata,
  output logic [XLEN/8-1:0]   memBe,
  input  logic [XLEN-1:0]     memRdata,
  output logic                ifStall,
  output logic                dStall
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0]        starve_cnt;
  logic              if_gnt;
  logic              d_gnt;
  logic [ADDR_W-1:0] addr_sel;
  logic              push_vld;

  logic [RD_LAT-1:0] tag_vld_p;
  logic [RD_LAT-1:0] tag_own_p;
  logic [RD_LAT-1:0] tag_sel_p;

  always_comb begin
    d_gnt  = dReq && (!ifReq || (starve_cnt < STARVE_LIM));
    if_gnt = ifReq && !d_gnt;
  end

  assign ifGnt   = if_gnt;
  assign dGnt    = d_gnt;
  assign ifStall = ifReq & ~if_gnt;
  assign dStall  = dReq & ~d_gnt;

  // Grant stage: drive the memory port from the winner
  assign addr_sel = d_gnt ? dAddr : ifAddr;
  assign memEn    = if_gnt | d_gnt;
  assign memWe    = d_gnt & dWe;
  assign memAddr  = addr_sel & ~ADDR_W'(7);
  assign memWdata = dWdata;
  assign memBe    = (d_gnt && dWe) ? dBe : '1;
  assign push_vld = memEn & ~memWe;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      starve_cnt <= '0;
    end else if (!ifReq || if_gnt) begin
      starve_cnt <= '0;
    end else if (d_gnt && (starve_cnt != STARVE_LIM)) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  // Tag pipe stages: flush kills every IF-owned entry moving forward, including the one pushed now
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tag_vld_p <= '0;
    end else begin
      tag_vld_p[0] <= push_vld & ~(flush & if_gnt);
      for (int i = 1; i < RD_LAT; i++) begin
        tag_vld_p[i] <= tag_vld_p[i-1] & ~(flush & tag_own_p[i-1]);
      end
    end
  end

  always_ff @(posedge clk) begin
    tag_own_p[0] <= if_gnt;
    tag_sel_p[0] <= ifAddr[2];
    for (int i = 1; i < RD_LAT; i++) begin
      tag_own_p[i] <= tag_own_p[i-1];
      tag_sel_p[i] <= tag_sel_p[i-1];
    end
  end

  // Return stage: tail of the tag pipe lines up with memRdata
  assign ifRvalid = tag_vld_p[RD_LAT-1] & tag_own_p[RD_LAT-1];
  assign dRvalid  = tag_vld_p[RD_LAT-1] & ~tag_own_p[RD_LAT-1];
  assign ifRdata  = !ifRvalid ? 32'd0 :
                    (tag_sel_p[RD_LAT-1] ? memRdata[32 +: 32] : memRdata[31:0]);
  assign dRdata   = dRvalid ? memRdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed bench for mem_port_arbiter against a queue-based return model.
module tb_mem_port_arbiter;
  localparam int XLEN = 64, ADDR_W = 32, RD_LAT = 2, SM = 3;

  logic clk, rstn;
  logic ifReq, ifGnt, ifRvalid;
  logic [ADDR_W-1:0] ifAddr;
  logic [31:0] ifRdata;
  logic dReq, dWe, dGnt, dRvalid;
  logic [ADDR_W-1:0] dAddr;
  logic [XLEN-1:0] dWdata, dRdata;
  logic [7:0] dBe;
  logic flush, memEn, memWe;
  logic [ADDR_W-1:0] memAddr;
  logic [XLEN-1:0] memWdata, memRdata;
  logic [7:0] memBe;
  logic ifStall, dStall;

  mem_port_arbiter #(.XLEN(XLEN), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .STARVE_MAX(SM)) dut (
    .clk(clk), .rstn(rstn),
    .ifReq(ifReq), .ifAddr(ifAddr), .ifGnt(ifGnt), .ifRvalid(ifRvalid), .ifRdata(ifRdata),
    .dReq(dReq), .dWe(dWe), .dAddr(dAddr), .dWdata(dWdata), .dBe(dBe),
    .dGnt(dGnt), .dRvalid(dRvalid), .dRdata(dRdata),
    .flush(flush), .memEn(memEn), .memWe(memWe), .memAddr(memAddr),
    .memWdata(memWdata), .memBe(memBe), .memRdata(memRdata),
    .ifStall(ifStall), .dStall(dStall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          due;
    bit          is_if;
    bit          killed;
    bit          sel;
    logic [63:0] data;
  } ret_t;

  ret_t q[$];
  int cyc = 0;
  int cnt = 0;
  int n_chk = 0;
  int n_err = 0;
  bit fix_en = 0;
  logic [63:0] fix_data = '0;
  bit g_if, g_d;
  logic o_ifgnt, o_dgnt, o_ifrv, o_drv, o_memwe, o_ifstall;
  logic [31:0] o_ifrdata;
  logic [63:0] o_drdata;
  logic [31:0] o_memaddr;
  logic [7:0] o_membe;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock cycle: inputs already driven just after the rising edge.
  task automatic tick();
    bit rv_if, rv_d, rsel;
    logic [63:0] rdata;
    ret_t e;
    rv_if = 0; rv_d = 0; rsel = 0; rdata = '0;
    memRdata = {$urandom, $urandom};
    foreach (q[k]) begin
      if (q[k].due == cyc) begin
        memRdata = q[k].data;
        rdata = q[k].data;
        rsel = q[k].sel;
        if (!q[k].killed) begin
          if (q[k].is_if) rv_if = 1; else rv_d = 1;
        end
      end
    end
    g_d  = dReq && (!ifReq || cnt < SM);
    g_if = ifReq && !g_d;
    @(negedge clk);
    o_ifgnt = ifGnt; o_dgnt = dGnt; o_ifrv = ifRvalid; o_drv = dRvalid;
    o_ifrdata = ifRdata; o_drdata = dRdata; o_memaddr = memAddr;
    o_membe = memBe; o_memwe = memWe; o_ifstall = ifStall;
    chk("ifGnt", ifGnt, g_if);
    chk("dGnt", dGnt, g_d);
    chk("memEn", memEn, g_if | g_d);
    chk("memWe", memWe, g_d & dWe);
    if (g_if | g_d) begin
      chk("memAddr", memAddr, (g_d ? dAddr : ifAddr) & 32'hFFFF_FFF8);
      chk("memBe", memBe, (g_d && dWe) ? dBe : 8'hFF);
    end
    if (g_d && dWe) chk("memWdata", memWdata, dWdata);
    chk("ifStall", ifStall, ifReq && !g_if);
    chk("dStall", dStall, dReq && !g_d);
    chk("ifRvalid", ifRvalid, rv_if);
    chk("dRvalid", dRvalid, rv_d);
    if (rv_if) chk("ifRdata", ifRdata, rsel ? rdata[63:32] : rdata[31:0]);
    if (rv_d) chk("dRdata", dRdata, rdata);
    @(posedge clk);
    if (!rstn) begin
      q.delete();
      cnt = 0;
    end else begin
      if (flush) foreach (q[k]) if (q[k].is_if && q[k].due > cyc) q[k].killed = 1;
      if ((g_if || (g_d && !dWe))) begin
        e.due = cyc + RD_LAT;
        e.is_if = g_if;
        e.killed = g_if && flush;
        e.sel = ifAddr[2];
        e.data = fix_en ? fix_data : {$urandom, $urandom};
        q.push_back(e);
      end
      if (!ifReq || g_if) cnt = 0;
      else if (g_d && cnt < SM) cnt = cnt + 1;
    end
    while (q.size() > 0 && q[0].due <= cyc) void'(q.pop_front());
    cyc++;
    #1;
  endtask

  task automatic idle();
    ifReq = 0; dReq = 0; dWe = 0; flush = 0;
  endtask

  logic [7:0] seq;

  initial begin
    rstn = 0; idle();
    ifAddr = '0; dAddr = '0; dWdata = '0; dBe = '0; memRdata = '0;
    repeat (2) @(posedge clk);
    #1 rstn = 1;

    // Reset state with no requests
    tick();
    chk("rst_ifrv", o_ifrv, 1'b0);
    chk("rst_drv", o_drv, 1'b0);
    chk("rst_ifrdata", o_ifrdata, 32'd0);
    chk("rst_drdata", o_drdata, 64'd0);
    chk("rst_memwe", o_memwe, 1'b0);

    // IF-only read at 0x104
    fix_en = 1; fix_data = 64'hAAAA_BBBB_1111_2222;
    ifReq = 1; ifAddr = 32'h104;
    tick();
    chk("t1_gnt", o_ifgnt, 1'b1);
    chk("t1_addr", o_memaddr, 32'h100);
    idle();
    tick();
    chk("t1_norv_early", o_ifrv, 1'b0);
    tick();
    chk("t1_rv", o_ifrv, 1'b1);
    chk("t1_rdata", o_ifrdata, 32'hAAAA_BBBB);
    tick();
    chk("t1_rv_once", o_ifrv, 1'b0);
    fix_en = 0;

    // Contested loads for 8 cycles
    seq = '0;
    ifReq = 1; ifAddr = 32'h200; dReq = 1; dWe = 0; dAddr = 32'h3008;
    for (int i = 0; i < 8; i++) begin
      tick();
      seq = {seq[6:0], o_dgnt};
    end
    chk("t2_seq", seq, 8'b1110_1110);
    idle();
    repeat (RD_LAT + 1) tick();

    // Store produces no return
    dReq = 1; dWe = 1; dAddr = 32'h20; dBe = 8'h0F; dWdata = 64'h1234;
    tick();
    chk("t3_we", o_memwe, 1'b1);
    chk("t3_be", o_membe, 8'h0F);
    chk("t3_addr", o_memaddr, 32'h20);
    idle();
    for (int i = 0; i < RD_LAT + 1; i++) begin
      tick();
      chk("t3_no_drv", o_drv, 1'b0);
    end

    // Flush kills the IF read, load survives
    ifReq = 1; ifAddr = 32'h400;
    tick();
    ifReq = 0; dReq = 1; dWe = 0; dAddr = 32'h808; flush = 1;
    tick();
    idle();
    tick();
    chk("t4_no_ifrv", o_ifrv, 1'b0);
    tick();
    chk("t4_drv", o_drv, 1'b1);
    tick();

    // Reset mid-operation
    ifReq = 1; ifAddr = 32'h500;
    tick();
    ifReq = 0; dReq = 1; dWe = 0; dAddr = 32'h600;
    rstn = 0; q.delete(); cnt = 0;
    tick();
    idle();
    tick();
    chk("t5_no_rv_a", o_ifrv | o_drv, 1'b0);
    rstn = 1;
    ifReq = 1; ifAddr = 32'h704;
    tick();
    chk("t5_gnt_after", o_ifgnt, 1'b1);
    chk("t5_no_rv_b", o_ifrv | o_drv, 1'b0);
    idle();
    tick();
    tick();
    chk("t5_rv_after", o_ifrv, 1'b1);

    // Data alone, then IF alone: no starvation carry-over
    dReq = 1; dWe = 0; dAddr = 32'h900;
    repeat (5) tick();
    dReq = 0; ifReq = 1; ifAddr = 32'hA00;
    tick();
    chk("t6_if_gnt", o_ifgnt, 1'b1);
    chk("t6_no_stall", o_ifstall, 1'b0);
    idle();
    repeat (RD_LAT + 1) tick();

    // Randomized traffic with hold-until-granted requesters
    for (int i = 0; i < 2000; i++) begin
      if (!ifReq || g_if) begin
        ifReq = ($urandom_range(0, 3) != 0);
        ifAddr = $urandom & 32'h0000_FFFC;
      end
      if (!dReq || g_d) begin
        dReq = ($urandom_range(0, 2) != 0);
        dWe = $urandom_range(0, 1);
        dAddr = $urandom & 32'h0000_FFFF;
        dWdata = {$urandom, $urandom};
        dBe = 8'($urandom);
      end
      flush = ($urandom_range(0, 7) == 0);
      tick();
    end
    idle();
    repeat (RD_LAT + 2) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
